// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache controller.
// The controller connects through the slave modport; the pipeline/memory side uses master.
interface dcache_if;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with 256-bit lines.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int SET_BITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  localparam int NSETS = 1 << SET_BITS;
  localparam int TAG_W = 27 - SET_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

  state_t             state_q, state_d;
  logic [NSETS-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [NSETS];
  logic [255:0]       line_q [NSETS];

  logic [2:0]          word;
  logic [SET_BITS-1:0] set;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                store_hit;
  logic                fill_ack;
  logic [31:0]         rd_word;
  logic                unused_addr;

  assign word        = bus.cpu_addr_i[4:2];
  assign set         = bus.cpu_addr_i[4+SET_BITS:5];
  assign tag         = bus.cpu_addr_i[31:5+SET_BITS];
  assign unused_addr = ^bus.cpu_addr_i[1:0];
  assign hit         = valid_q[set] & (tag_q[set] == tag);
  assign rd_word     = line_q[set][{word, 5'b0} +: 32];
  assign store_hit   = (state_q == IDLE) & bus.cpu_req_i & bus.cpu_we_i & hit;
  assign fill_ack    = (state_q == ALLOCATE) & bus.mem_ack_i;

  always_comb begin
    state_d          = state_q;
    bus.cpu_stall_o  = 1'b1;
    bus.cpu_data_o   = '0;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        bus.cpu_stall_o = bus.cpu_req_i & ~hit;
        if (bus.cpu_req_i & ~bus.cpu_we_i & hit) bus.cpu_data_o = rd_word;
        if (bus.cpu_req_i & ~hit)
          state_d = (valid_q[set] & dirty_q[set]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {tag_q[set], set, 5'b0};
        bus.mem_data_o   = line_q[set];
        if (bus.mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {bus.cpu_addr_i[31:5], 5'b0};
        if (bus.mem_ack_i) state_d = REFILL;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM and per-set valid/dirty flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_ack) begin
        valid_q[set] <= 1'b1;
        dirty_q[set] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[set] <= 1'b1;
      end
    end
  end

  // Tag and line storage; contents are meaningless while the valid bit is clear
  always_ff @(posedge clk_i) begin
    if (fill_ack) begin
      line_q[set] <= bus.mem_data_i;
      tag_q[set]  <= tag;
    end else if (store_hit) begin
      line_q[set][{word, 5'b0} +: 32] <= bus.cpu_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic from_refill_q;

  // The access completing right after REFILL already counted as a miss
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_count_o   <= '0;
      miss_count_o  <= '0;
      from_refill_q <= 1'b0;
    end else begin
      from_refill_q <= (state_q == REFILL);
      if ((state_q == IDLE) & bus.cpu_req_i & hit & ~from_refill_q)
        hit_count_o <= hit_count_o + 32'd1;
      if ((state_q == IDLE) & bus.cpu_req_i & ~hit)
        miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a table of CPU accesses against a behavioural line memory,
// plus hand-written reset and idle sequences.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_ctrl #(.SET_BITS(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wb_n;
    int          fill_n;
    int          exp_stall;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs [10];

  int nchk = 0;
  int nerr = 0;

  logic [255:0] mem_m [logic [26:0]];
  logic [31:0]  wb_addr;
  logic [255:0] wb_data;
  logic [31:0]  fill_addr;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mem_line(input logic [26:0] la);
    logic [255:0] l;
    if (mem_m.exists(la)) return mem_m[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = 32'hA500_0000 | {la, w[2:0], 2'b00};
    return l;
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_access(input vec_t v);
    int  stall_cnt = 0;
    int  k = 0;
    logic pen = 1'b0, pwe = 1'b0;
    logic done = 1'b0;
    logic saw_fill = 1'b0;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = v.we;
    bus.cpu_addr_i = v.addr;
    bus.cpu_data_i = v.wdata;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      bus.mem_ack_i = 1'b0;
      if (!bus.cpu_stall_o) begin
        if (!v.we) chk({v.name, " rdata"}, bus.cpu_data_o, v.exp_rd);
        chk({v.name, " mem_enable at completion"}, bus.mem_enable_o, 1'b0);
        done = 1'b1;
      end else begin
        stall_cnt++;
        if (stall_cnt == 1) chk({v.name, " cpu_data while stalled"}, bus.cpu_data_o, 32'h0);
        if (bus.mem_enable_o) begin
          k = (pen && pwe == bus.mem_write_o) ? k + 1 : 1;
          if (bus.mem_write_o) begin
            wb_addr = bus.mem_addr_o;
            wb_data = bus.mem_data_o;
            if (k == v.wb_n) begin
              bus.mem_ack_i = 1'b1;
              mem_m[bus.mem_addr_o[31:5]] = bus.mem_data_o;
            end
          end else begin
            fill_addr = bus.mem_addr_o;
            saw_fill  = 1'b1;
            if (k == v.fill_n) begin
              bus.mem_ack_i  = 1'b1;
              bus.mem_data_i = mem_line(bus.mem_addr_o[31:5]);
            end
          end
        end
        pen = bus.mem_enable_o;
        pwe = bus.mem_write_o;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      nchk++; nerr++;
      $display("FAIL %s timeout: stall still high after %0d cycles", v.name, stall_cnt);
    end
    chk({v.name, " stall cycles"}, stall_cnt, v.exp_stall);
    if (v.fill_n > 0) begin
      chk({v.name, " fill issued"}, saw_fill, 1'b1);
      chk({v.name, " fill addr"}, fill_addr, {v.addr[31:5], 5'b0});
    end
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b0;
    bus.mem_ack_i = 1'b0;
  endtask

  initial begin
    logic [255:0] l40;
    for (int w = 0; w < 8; w++) l40[32*w +: 32] = 32'h1000_0000 + w;
    l40[31:0] = 32'hDEAD_BEEF;
    mem_m[27'h2] = l40;

    vecs[0] = '{1'b0, 32'h40,  32'h0,         0, 3, 5, 32'hDEAD_BEEF, "ld40 clean miss"};
    vecs[1] = '{1'b0, 32'h44,  32'h0,         0, 0, 0, 32'h1000_0001, "ld44 hit"};
    vecs[2] = '{1'b1, 32'h48,  32'h1234_5678, 0, 0, 0, 32'h0,         "st48 hit"};
    vecs[3] = '{1'b0, 32'h248, 32'h0,         2, 1, 5, 32'hA500_0248, "ld248 dirty miss"};
    vecs[4] = '{1'b1, 32'hA0,  32'hCAFE_F00D, 0, 1, 3, 32'h0,         "stA0 miss"};
    vecs[5] = '{1'b0, 32'hA0,  32'h0,         0, 0, 0, 32'hCAFE_F00D, "ldA0 hit"};
    vecs[6] = '{1'b0, 32'h48,  32'h0,         0, 1, 3, 32'h1234_5678, "ld48 refetch"};
    vecs[7] = '{1'b1, 32'h4C,  32'h55AA_55AA, 0, 0, 0, 32'h0,         "st4C hit"};
    vecs[8] = '{1'b0, 32'h24C, 32'h0,         1, 1, 4, 32'hA500_024C, "ld24C dirty miss"};
    vecs[9] = '{1'b0, 32'h4C,  32'h0,         0, 1, 3, 32'h55AA_55AA, "ld4C refetch"};

    bus.cpu_req_i  = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h0;
    bus.cpu_data_i = 32'h0;
    bus.mem_data_i = '0;
    bus.mem_ack_i  = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("reset stall idle", bus.cpu_stall_o, 1'b0);
    chk("reset mem_enable", bus.mem_enable_o, 1'b0);
    chk("reset mem_write", bus.mem_write_o, 1'b0);
    chk("reset mem_addr", bus.mem_addr_o, 32'h0);
    chk("reset mem_data", bus.mem_data_o, 256'h0);
    chk("reset cpu_data", bus.cpu_data_o, 32'h0);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h40;
    #1;
    chk("reset stall follows req", bus.cpu_stall_o, 1'b1);
    bus.cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_access(vecs[i]);
    chk("wb addr", wb_addr, 32'h40);
    chk("wb word2", wb_data[95:64], 32'h1234_5678);
    chk("wb word0", wb_data[31:0], 32'hDEAD_BEEF);
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, 32'd2);
    chk("miss_count", miss_count, 32'd2);
`endif
    for (int i = 4; i < 10; i++) run_access(vecs[i]);
    chk("wb2 addr", wb_addr, 32'h40);
    chk("wb2 word3", wb_data[127:96], 32'h55AA_55AA);

    // No request: nothing moves
    #1;
    chk("idle stall", bus.cpu_stall_o, 1'b0);
    chk("idle mem_enable", bus.mem_enable_o, 1'b0);
    @(posedge clk); #2;
    chk("idle mem_enable later", bus.mem_enable_o, 1'b0);

    // Reset while ALLOCATE waits for its ack
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h300;
    #1;
    chk("rst seq miss stall", bus.cpu_stall_o, 1'b1);
    @(posedge clk); #2;
    chk("rst seq allocate enable", bus.mem_enable_o, 1'b1);
    chk("rst seq allocate addr", bus.mem_addr_o, 32'h300);
    rst = 1'b1;
    bus.cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst seq enable dropped", bus.mem_enable_o, 1'b0);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = {8{32'hFFFF_FFFF}};
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0;
    #1;
    chk("rst seq late ack ignored", bus.mem_enable_o, 1'b0);
    chk("rst seq stall after late ack", bus.cpu_stall_o, 1'b0);
    @(posedge clk); #1;
    run_access('{1'b0, 32'h300, 32'h0, 0, 2, 4, 32'hA500_0300, "ld300 after reset"});
    run_access('{1'b0, 32'hA0,  32'h0, 0, 1, 3, 32'hA500_00A0, "ldA0 dirty lost"});

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", nchk);
    $fatal(1, "watchdog");
  end

endmodule
